// File: rtl/enc_8to3_sync_if.sv
// Request/grant bundle for the 8-to-3 priority encoder: request side in,
// encoded index and pending status out.
interface enc_8to3_sync_if;
    logic [7:0] req;
    logic [7:0] mask;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pending;
    logic       any_pend;

    modport master (
        output req,
        output mask,
        output ack,
        input  code,
        input  valid,
        input  pending,
        input  any_pend
    );

    modport slave (
        input  req,
        input  mask,
        input  ack,
        output code,
        output valid,
        output pending,
        output any_pend
    );
endinterface

// File: rtl/enc_8to3_sync.sv
// Registered 8-to-3 priority encoder: latches requests, arbitrates only from the
// pending register, and holds the selected index until the consumer acknowledges.
module enc_8to3_sync #(
    parameter bit PRIO_MSB = 1'b1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    enc_8to3_sync_if.slave  bus
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t     r_state;
    logic [2:0] r_code;
    logic       r_valid;
    logic [7:0] r_pending;

    state_t     w_next_state;
    logic [2:0] w_next_code;
    logic       w_next_valid;
    logic [7:0] w_next_pending;
    logic [7:0] w_elig;
    logic [7:0] w_clr;

    // Later loop iterations overwrite earlier ones, so scan order sets the winner.
    function automatic logic [2:0] prio_index(input logic [7:0] vec);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIO_MSB) begin
            for (int i = 0; i < 8; i++) begin
                if (vec[i]) idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (vec[i]) idx = 3'(i);
            end
        end
        return idx;
    endfunction

    // Next-state, arbitration and pending-bit update.
    always_comb begin
        w_elig       = r_pending & ~bus.mask;
        w_clr        = 8'h00;
        w_next_state = r_state;
        w_next_code  = r_code;
        w_next_valid = r_valid;
        case (r_state)
            ST_IDLE: begin
                if (w_elig != 8'h00) begin
                    w_next_code  = prio_index(w_elig);
                    w_next_valid = 1'b1;
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_valid = 1'b0;
                    w_next_state = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (bus.ack && r_valid) begin
                    w_clr        = 8'h01 << r_code;
                    w_next_valid = 1'b0;
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_valid = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            default: begin
                w_next_code  = 3'd0;
                w_next_valid = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
        // OR-ing req last lets a same-edge re-request survive its own clear.
        w_next_pending = (r_pending & ~w_clr) | bus.req;
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_code    <= 3'd0;
            r_valid   <= 1'b0;
            r_pending <= 8'h00;
        end else begin
            r_state   <= w_next_state;
            r_code    <= w_next_code;
            r_valid   <= w_next_valid;
            r_pending <= w_next_pending;
        end
    end

    assign bus.code     = r_code;
    assign bus.valid    = r_valid;
    assign bus.pending  = r_pending;
    assign bus.any_pend = |r_pending;

endmodule

// File: tb/tb_enc_8to3_sync.sv
// Scoreboard bench for enc_8to3_sync: one MSB-priority and one LSB-priority
// instance share stimulus; each valid rising edge pops its expected code.
module tb_enc_8to3_sync;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   exp_m[$];
    int   exp_l[$];
    logic prev_valid_m;
    logic prev_valid_l;
    int   exp_code_m;
    int   exp_code_l;

    enc_8to3_sync_if bus_m();
    enc_8to3_sync_if bus_l();

    enc_8to3_sync #(.PRIO_MSB(1'b1)) dut_m (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_m.slave)
    );

    enc_8to3_sync #(.PRIO_MSB(1'b0)) dut_l (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus_l.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs == exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [7:0] r, input logic [7:0] m, input logic a);
        bus_m.req  = r;
        bus_m.mask = m;
        bus_m.ack  = a;
        bus_l.req  = r;
        bus_l.mask = m;
        bus_l.ack  = a;
    endtask

    task automatic drain(input string tag);
        int n;
        n = 0;
        while ((bus_m.valid || bus_m.pending != 8'h00 ||
                bus_l.valid || bus_l.pending != 8'h00) && n < 40) begin
            tick();
            n++;
        end
        check_val({tag, "_done"}, (n < 40) ? 1 : 0, 1);
        check_val({tag, "_qm_empty"}, exp_m.size(), 0);
        check_val({tag, "_ql_empty"}, exp_l.size(), 0);
    endtask

    // Scoreboard pop for the MSB-priority instance on each new valid.
    always @(negedge clk) begin
        if (bus_m.valid === 1'b1 && prev_valid_m !== 1'b1) begin
            if (exp_m.size() == 0) begin
                check_val("unexpected_valid_m", 1, 0);
            end else begin
                exp_code_m = exp_m.pop_front();
                check_val("sb_code_m", int'(bus_m.code), exp_code_m);
            end
        end
        prev_valid_m <= bus_m.valid;
    end

    // Scoreboard pop for the LSB-priority instance on each new valid.
    always @(negedge clk) begin
        if (bus_l.valid === 1'b1 && prev_valid_l !== 1'b1) begin
            if (exp_l.size() == 0) begin
                check_val("unexpected_valid_l", 1, 0);
            end else begin
                exp_code_l = exp_l.pop_front();
                check_val("sb_code_l", int'(bus_l.code), exp_code_l);
            end
        end
        prev_valid_l <= bus_l.valid;
    end

    initial begin
        n_checks     = 0;
        n_pass       = 0;
        prev_valid_m = 1'b0;
        prev_valid_l = 1'b0;

        // Reset with requests and ack asserted must leave everything clear.
        rst_n = 1'b0;
        drive(8'hFF, 8'h00, 1'b1);
        repeat (3) tick();
        check_val("rst_pending_m", int'(bus_m.pending), 0);
        check_val("rst_pending_l", int'(bus_l.pending), 0);
        check_val("rst_valid_m", int'(bus_m.valid), 0);
        check_val("rst_code_m", int'(bus_m.code), 0);
        check_val("rst_any_pend_m", int'(bus_m.any_pend), 0);
        rst_n = 1'b1;
        drive(8'h00, 8'h00, 1'b0);
        tick();

        // Single request: two-edge latency, code held while ack is low.
        exp_m.push_back(5);
        exp_l.push_back(5);
        drive(8'h20, 8'h00, 1'b0);
        tick();
        check_val("single_pending_e0", int'(bus_m.pending), 32);
        check_val("single_valid_e0", int'(bus_m.valid), 0);
        check_val("single_any_pend", int'(bus_m.any_pend), 1);
        drive(8'h00, 8'h00, 1'b0);
        tick();
        check_val("single_valid_e1", int'(bus_m.valid), 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val("single_hold_code", int'(bus_m.code), 5);
            check_val("single_hold_valid", int'(bus_l.valid), 1);
        end
        drive(8'h00, 8'h00, 1'b1);
        tick();
        check_val("single_ack_pending", int'(bus_m.pending), 0);
        check_val("single_ack_valid", int'(bus_m.valid), 0);
        drive(8'h00, 8'h00, 1'b0);
        tick();

        // Priority order with ack held high throughout.
        exp_m.push_back(7); exp_m.push_back(4); exp_m.push_back(0);
        exp_l.push_back(0); exp_l.push_back(4); exp_l.push_back(7);
        drive(8'h91, 8'h00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b1);
        drain("prio");
        drive(8'h00, 8'h00, 1'b0);
        tick();

        // Masked bit stays latched and is served once unmasked.
        exp_m.push_back(2);
        exp_l.push_back(2);
        drive(8'h0C, 8'h08, 1'b0);
        tick();
        drive(8'h00, 8'h08, 1'b0);
        tick();
        check_val("mask_code", int'(bus_m.code), 2);
        drive(8'h00, 8'h08, 1'b1);
        tick();
        drive(8'h00, 8'h08, 1'b0);
        repeat (3) tick();
        check_val("mask_idle_valid", int'(bus_m.valid), 0);
        check_val("mask_held_pending", int'(bus_m.pending), 8);
        exp_m.push_back(3);
        exp_l.push_back(3);
        drive(8'h00, 8'h00, 1'b0);
        repeat (2) tick();
        check_val("unmask_valid", int'(bus_m.valid), 1);
        check_val("unmask_code", int'(bus_m.code), 3);
        drive(8'h00, 8'h00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        drain("mask");

        // Set wins over clear on the acknowledging edge.
        exp_m.push_back(3); exp_m.push_back(3);
        exp_l.push_back(3); exp_l.push_back(3);
        drive(8'h08, 8'h00, 1'b0);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        tick();
        drive(8'h08, 8'h00, 1'b1);
        tick();
        check_val("soc_pending", int'(bus_m.pending), 8);
        check_val("soc_bubble", int'(bus_m.valid), 0);
        drive(8'h00, 8'h00, 1'b0);
        tick();
        check_val("soc_reissue_code", int'(bus_m.code), 3);
        drive(8'h00, 8'h00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        drain("soc");

        // A higher-index request arriving during HOLD does not preempt.
        exp_m.push_back(1); exp_m.push_back(7);
        exp_l.push_back(1); exp_l.push_back(7);
        drive(8'h02, 8'h00, 1'b0);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        tick();
        drive(8'h80, 8'h00, 1'b0);
        tick();
        check_val("reentry_hold_code", int'(bus_m.code), 1);
        check_val("reentry_pending", int'(bus_m.pending), 130);
        drive(8'h00, 8'h00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        tick();
        drive(8'h00, 8'h00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        drain("reentry");

        // All eight bits pending are served in priority order.
        for (int i = 7; i >= 0; i--) exp_m.push_back(i);
        for (int i = 0; i < 8; i++) exp_l.push_back(i);
        drive(8'hFF, 8'h00, 1'b1);
        tick();
        drive(8'h00, 8'h00, 1'b1);
        drain("all8");
        drive(8'h00, 8'h00, 1'b0);
        tick();

        // Reset mid-handshake drops the code and pending bits.
        exp_m.push_back(6);
        exp_l.push_back(0);
        drive(8'h41, 8'h00, 1'b0);
        tick();
        drive(8'h00, 8'h00, 1'b0);
        tick();
        check_val("midrst_pre_code", int'(bus_m.code), 6);
        check_val("midrst_pre_pending", int'(bus_m.pending), 65);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_val("midrst_valid_m", int'(bus_m.valid), 0);
        check_val("midrst_pending_m", int'(bus_m.pending), 0);
        check_val("midrst_pending_l", int'(bus_l.pending), 0);
        check_val("midrst_code_m", int'(bus_m.code), 0);
        repeat (4) tick();
        check_val("postrst_valid_m", int'(bus_m.valid), 0);
        check_val("postrst_valid_l", int'(bus_l.valid), 0);
        check_val("postrst_qm_empty", exp_m.size(), 0);
        check_val("postrst_ql_empty", exp_l.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
